cdnsusbhs_spram_mc: RTL and testbench

//  Multi-channel single-port on-chip RAM for the ADMA data buffer. Successor to the single-requester SPRAM.
//  NUM_CH requesters are round-robin arbitrated onto one behavioural RAM port. Writes carry byte enables.

---
 rtl/cdnsusbhs_spram_mc_pkg.sv | 30 +++
 rtl/cdnsusbhs_spram_mc_if.sv | 45 ++++
 rtl/cdnsusbhs_spram_mc_core.sv | 46 ++++
 rtl/cdnsusbhs_spram_mc.sv | 176 +++++++++++++++++
 tb/tb_cdnsusbhs_spram_mc.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cdnsusbhs_spram_mc_pkg.sv
// -----------------------------------------------------------------------------
// cdnsusbhs_spram_mc_pkg
// Shared definitions for the multi-channel ADMA buffer SPRAM.
//   - Default buffer geometry (word width / number of words).
//   - Fixed read latency constant, grant-to-data, in clock cycles.
//   - Access-kind encoding carried down the read-return pipeline.
//   - Per-byte even-parity helper, used when CDNSUSBHS_SPRAM_MC_PARITY_EN
//     is defined.
// -----------------------------------------------------------------------------
package cdnsusbhs_spram_mc_pkg;

    localparam int CDNSUSBHS_ADMAMEMORY_WIDTH = 32;
    localparam int CDNSUSBHS_ADMAMEMORY_SIZE  = 128;
    localparam int CDNSUSBHS_SPRAM_MC_RD_LAT  = 2;

    // Kind of access granted in a cycle, remembered for one stage so the
    // second pipeline stage knows whether to return RAM data or zero.
    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2,
        ACC_DROP  = 2'd3   // out-of-range access: write dropped, read returns 0
    } acc_e;

    // Even parity: the stored bit makes the 9-bit lane have an even count of ones.
    function automatic logic even_par8(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/cdnsusbhs_spram_mc_if.sv
// -----------------------------------------------------------------------------
// cdnsusbhs_spram_mc_if
// Request / read-return bundle between NUM_CH ADMA channel engines and the
// multi-channel SPRAM.
//   ch_req   : per-channel request, held until granted
//   ch_we    : 1=write, 0=read
//   ch_addr  : channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   ch_wdata : channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ch_be    : channel i at [i*DATA_WIDTH/8 +: DATA_WIDTH/8]
//   ch_gnt   : one-hot combinational grant
//   rd_valid : one-hot tag for rd_data
//   rd_data  : registered read data
//   addr_err : pulse one cycle after an out-of-range access
//   par_err  : pulse with rd_valid on a parity mismatch
// Modports: master = channel side, slave = RAM side.
// -----------------------------------------------------------------------------
interface cdnsusbhs_spram_mc_if #(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_CH-1:0]                ch_req;
    logic [NUM_CH-1:0]                ch_we;
    logic [NUM_CH*ADDR_WIDTH-1:0]     ch_addr;
    logic [NUM_CH*DATA_WIDTH-1:0]     ch_wdata;
    logic [NUM_CH*(DATA_WIDTH/8)-1:0] ch_be;
    logic [NUM_CH-1:0]                ch_gnt;
    logic [NUM_CH-1:0]                rd_valid;
    logic [DATA_WIDTH-1:0]            rd_data;
    logic                             addr_err;
    logic                             par_err;

    // Handshake: an access is accepted in the cycle where ch_req[i] and
    // ch_gnt[i] are both high; the requester holds ch_req and its command
    // stable until then and may change or drop it in the following cycle.
    modport master (
        output ch_req, ch_we, ch_addr, ch_wdata, ch_be,
        input  ch_gnt, rd_valid, rd_data, addr_err, par_err
    );

    modport slave (
        input  ch_req, ch_we, ch_addr, ch_wdata, ch_be,
        output ch_gnt, rd_valid, rd_data, addr_err, par_err
    );
endinterface

// File: rtl/cdnsusbhs_spram_mc_core.sv
// -----------------------------------------------------------------------------
// cdnsusbhs_spram_core
// Behavioural single-port storage array, MEMORY_DEPTH words of
// NUM_LANES x LANE_W bits. This is the only piece swapped for a hard macro.
//   clk  : rising-edge clock
//   addr : word address (caller guarantees addr < MEMORY_DEPTH when en=1)
//   din  : write data, lane k at [k*LANE_W +: LANE_W]
//   bwe  : per-lane write enable
//   en   : access enable; dout updates only on enabled cycles
//   dout : registered read data, one cycle after the enabled access
// Contents are not reset.
// -----------------------------------------------------------------------------
module cdnsusbhs_spram_core #(
    parameter int ADDR_WIDTH   = 7,
    parameter int MEMORY_DEPTH = 128,
    parameter int NUM_LANES    = 4,
    parameter int LANE_W       = 8
) (
    input  logic                          clk,
    input  logic [ADDR_WIDTH-1:0]         addr,
    input  logic [NUM_LANES*LANE_W-1:0]   din,
    input  logic [NUM_LANES-1:0]          bwe,
    input  logic                          en,
    output logic [NUM_LANES*LANE_W-1:0]   dout
);
    localparam int WORD_W = NUM_LANES * LANE_W;

    logic [WORD_W-1:0] r_mem [MEMORY_DEPTH];
    logic [WORD_W-1:0] r_dout;

    // Read-first: a write and the read of the same enabled cycle return the
    // old word; the next access sees the new one.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (bwe[k]) begin
                    r_mem[addr][k*LANE_W +: LANE_W] <= din[k*LANE_W +: LANE_W];
                end
            end
            r_dout <= r_mem[addr];
        end
    end

    assign dout = r_dout;

endmodule

// File: rtl/cdnsusbhs_spram_mc.sv
// -----------------------------------------------------------------------------
// cdnsusbhs_spram_mc
// Multi-channel single-port RAM for the ADMA data buffer. NUM_CH requesters
// are round-robin arbitrated onto one port of cdnsusbhs_spram_core.
// Writes use byte enables; reads return 2 cycles after grant, tagged one-hot
// with the requesting channel; out-of-range accesses are flagged.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : cdnsusbhs_spram_mc_if.slave (requests, grant, read return, errors)
// Optional feature: CDNSUSBHS_SPRAM_MC_PARITY_EN adds one even-parity bit per
// byte to the stored word and raises par_err on a mismatching in-range read.
// -----------------------------------------------------------------------------
module cdnsusbhs_spram_mc
    import cdnsusbhs_spram_mc_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int ADDR_WIDTH   = 7,
    parameter int DATA_WIDTH   = CDNSUSBHS_ADMAMEMORY_WIDTH,
    parameter int MEMORY_DEPTH = CDNSUSBHS_ADMAMEMORY_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cdnsusbhs_spram_mc_if.slave  bus
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef CDNSUSBHS_SPRAM_MC_PARITY_EN
    localparam int LANE_W = 9;   // {parity, byte}
`else
    localparam int LANE_W = 8;
`endif
    localparam int MEM_W = NB * LANE_W;

    // ---------------- round-robin arbiter ----------------
    logic [PTR_W-1:0]      r_rr_ptr;
    logic [PTR_W-1:0]      w_sel;
    logic                  w_any;
    logic [NUM_CH-1:0]     w_gnt;
    int                    w_idx;

    // Scan from the farthest offset to the nearest so the first requester at
    // or after r_rr_ptr (modulo NUM_CH) is the one left in w_sel.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_idx = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_idx = int'(r_rr_ptr) + i;
            if (w_idx >= NUM_CH) begin
                w_idx = w_idx - NUM_CH;
            end
            if (bus.ch_req[w_idx]) begin
                w_any = 1'b1;
                w_sel = PTR_W'(w_idx);
            end
        end
    end

    always_comb begin
        w_gnt = '0;
        if (w_any) begin
            w_gnt[w_sel] = 1'b1;
        end
    end

    assign bus.ch_gnt = w_gnt;

    // ---------------- request mux and range check ----------------
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [NB-1:0]         w_be;
    logic                  w_in_range;
    logic                  w_en;
    logic [NB-1:0]         w_bwe;

    assign w_we       = bus.ch_we[w_sel];
    assign w_addr     = bus.ch_addr[int'(w_sel)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata    = bus.ch_wdata[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
    assign w_be       = bus.ch_be[int'(w_sel)*NB +: NB];
    assign w_in_range = ({1'b0, w_addr} < (ADDR_WIDTH+1)'(MEMORY_DEPTH));
    // Out-of-range accesses never reach the array, so dropped writes cannot
    // alias onto a real word.
    assign w_en       = w_any && w_in_range;
    assign w_bwe      = w_we ? w_be : '0;

    // ---------------- lane packing / parity ----------------
    logic [MEM_W-1:0]      w_din;
    logic [MEM_W-1:0]      w_dout;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_par_bad;

    always_comb begin
        w_din     = '0;
        w_rdata   = '0;
        w_par_bad = 1'b0;
        for (int k = 0; k < NB; k++) begin
            w_din[k*LANE_W +: 8] = w_wdata[k*8 +: 8];
            w_rdata[k*8 +: 8]    = w_dout[k*LANE_W +: 8];
`ifdef CDNSUSBHS_SPRAM_MC_PARITY_EN
            w_din[k*LANE_W + 8] = even_par8(w_wdata[k*8 +: 8]);
            if (w_dout[k*LANE_W + 8] != even_par8(w_dout[k*LANE_W +: 8])) begin
                w_par_bad = 1'b1;
            end
`endif
        end
    end

    cdnsusbhs_spram_core #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .MEMORY_DEPTH (MEMORY_DEPTH),
        .NUM_LANES    (NB),
        .LANE_W       (LANE_W)
    ) u_core (
        .clk  (clk),
        .addr (w_addr),
        .din  (w_din),
        .bwe  (w_bwe),
        .en   (w_en),
        .dout (w_dout)
    );

    // ---------------- read-return pipeline ----------------
    // Stage 1 (T+1) lines up with the core's registered dout; stage 2 (T+2)
    // registers the returned word together with its one-hot channel tag.
    logic [NUM_CH-1:0]     r_s1_tag;
    acc_e                  r_s1_kind;
    logic                  r_addr_err;
    logic [NUM_CH-1:0]     r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_par_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_s1_tag   <= '0;
            r_s1_kind  <= ACC_IDLE;
            r_addr_err <= 1'b0;
            r_rd_valid <= '0;
            r_rd_data  <= '0;
            r_par_err  <= 1'b0;
        end else begin
            if (w_any) begin
                r_rr_ptr <= (w_sel == PTR_W'(NUM_CH - 1)) ? '0 : w_sel + 1'b1;
            end

            r_addr_err <= w_any && !w_in_range;
            r_s1_tag   <= (w_any && !w_we) ? w_gnt : '0;

            if (!w_any) begin
                r_s1_kind <= ACC_IDLE;
            end else if (!w_in_range) begin
                r_s1_kind <= ACC_DROP;
            end else if (w_we) begin
                r_s1_kind <= ACC_WRITE;
            end else begin
                r_s1_kind <= ACC_READ;
            end

            r_rd_valid <= r_s1_tag;
            if (|r_s1_tag) begin
                // rd_data only moves on a returning read, otherwise it holds.
                r_rd_data <= (r_s1_kind == ACC_READ) ? w_rdata : '0;
                r_par_err <= (r_s1_kind == ACC_READ) && w_par_bad;
            end else begin
                r_par_err <= 1'b0;
            end
        end
    end

    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;
    assign bus.addr_err = r_addr_err;
    assign bus.par_err  = r_par_err;

endmodule

// File: tb/tb_cdnsusbhs_spram_mc.sv
`timescale 1ns/1ps
module tb_cdnsusbhs_spram_mc;
    import cdnsusbhs_spram_mc_pkg::*;

    localparam int NUM_CH = 2;
    localparam int AW     = 7;
    localparam int DW     = 32;
    localparam int DEPTH  = 100;
    localparam int NB     = DW / 8;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cdnsusbhs_spram_mc_if #(.NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    cdnsusbhs_spram_mc #(
        .NUM_CH       (NUM_CH),
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .MEMORY_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] last_rd = '0;
    logic [NUM_CH+DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic clear_reqs();
        bus.ch_req   = '0;
        bus.ch_we    = '0;
        bus.ch_addr  = '0;
        bus.ch_wdata = '0;
        bus.ch_be    = '0;
    endtask

    task automatic set_cmd(input int ch, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [NB-1:0] be);
        bus.ch_req[ch]             = 1'b1;
        bus.ch_we[ch]              = we;
        bus.ch_addr[ch*AW +: AW]   = addr;
        bus.ch_wdata[ch*DW +: DW]  = wdata;
        bus.ch_be[ch*NB +: NB]     = be;
    endtask

    // One isolated access from one channel: grant, T+1 addr_err, T+2 return.
    task automatic do_access(input string name, input int ch, input logic we,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                             input logic [NB-1:0] be, input logic [DW-1:0] exp_data,
                             input logic exp_err, input logic exp_par);
        int waited;
        logic [NUM_CH-1:0] exp_tag;
        waited = 0;
        @(negedge clk);
        clear_reqs();
        set_cmd(ch, we, addr, wdata, be);
        #1;
        while (bus.ch_gnt[ch] !== 1'b1 && waited < 8) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check({name, ".gnt"}, 64'(bus.ch_gnt), 64'(1) << ch);
        @(negedge clk);
        clear_reqs();
        check({name, ".addr_err"}, 64'(bus.addr_err), 64'(exp_err));
        @(negedge clk);
        exp_tag = '0;
        if (!we) begin
            exp_tag[ch] = 1'b1;
            last_rd = exp_data;
        end
        check({name, ".rd_valid"}, 64'(bus.rd_valid), 64'(exp_tag));
        check({name, ".rd_data"},  64'(bus.rd_data),  64'(last_rd));
        check({name, ".par_err"},  64'(bus.par_err),  64'(exp_par));
        check({name, ".err_pulse"}, 64'(bus.addr_err), 64'(0));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int            ch;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [NB-1:0] be;
        logic [DW-1:0] exp_data;
        logic          exp_err;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs[NVEC];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_CH+DW-1:0] e;
        logic [NUM_CH-1:0]    g;

        vecs[0]  = '{0, 1'b1, 7'd5,   32'hA5A5_1234, 4'hF, 32'h0,         1'b0};
        vecs[1]  = '{0, 1'b0, 7'd5,   32'h0,         4'h0, 32'hA5A5_1234, 1'b0};
        vecs[2]  = '{1, 1'b1, 7'd3,   32'hFFFF_FFFF, 4'hF, 32'h0,         1'b0};
        vecs[3]  = '{1, 1'b1, 7'd3,   32'h0000_0000, 4'h5, 32'h0,         1'b0};
        vecs[4]  = '{0, 1'b0, 7'd3,   32'h0,         4'h0, 32'hFF00_FF00, 1'b0};
        vecs[5]  = '{1, 1'b1, 7'd99,  32'h1234_5678, 4'hF, 32'h0,         1'b0};
        vecs[6]  = '{0, 1'b1, 7'd100, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b1};
        vecs[7]  = '{1, 1'b0, 7'd100, 32'h0,         4'h0, 32'h0,         1'b1};
        vecs[8]  = '{0, 1'b0, 7'd99,  32'h0,         4'h0, 32'h1234_5678, 1'b0};
        vecs[9]  = '{0, 1'b1, 7'd10,  32'h1122_3344, 4'hF, 32'h0,         1'b0};
        vecs[10] = '{1, 1'b1, 7'd10,  32'hCAFE_F00D, 4'h0, 32'h0,         1'b0};
        vecs[11] = '{1, 1'b0, 7'd10,  32'h0,         4'h0, 32'h1122_3344, 1'b0};
        vecs[12] = '{0, 1'b1, 7'd127, 32'h5555_5555, 4'hF, 32'h0,         1'b1};
        vecs[13] = '{0, 1'b1, 7'd0,   32'h0000_0000, 4'hF, 32'h0,         1'b0};
        vecs[14] = '{1, 1'b1, 7'd0,   32'h5A5A_5A5A, 4'h8, 32'h0,         1'b0};
        vecs[15] = '{1, 1'b0, 7'd0,   32'h0,         4'h0, 32'h5A00_0000, 1'b0};
        vecs[16] = '{0, 1'b0, 7'd99,  32'h0,         4'h0, 32'h1234_5678, 1'b0};
        vecs[17] = '{1, 1'b0, 7'd3,   32'h0,         4'h0, 32'hFF00_FF00, 1'b0};

        // ---------------- reset state ----------------
        clear_reqs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.rd_valid", 64'(bus.rd_valid), 64'(0));
        check("rst.rd_data",  64'(bus.rd_data),  64'(0));
        check("rst.addr_err", 64'(bus.addr_err), 64'(0));
        check("rst.par_err",  64'(bus.par_err),  64'(0));
        check("rst.gnt_idle", 64'(bus.ch_gnt),   64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle.gnt", 64'(bus.ch_gnt), 64'(0));

        // ---------------- table ----------------
        for (int v = 0; v < NVEC; v++) begin
            do_access($sformatf("vec%0d", v), vecs[v].ch, vecs[v].we, vecs[v].addr,
                      vecs[v].wdata, vecs[v].be, vecs[v].exp_data, vecs[v].exp_err, 1'b0);
        end

        // ---------------- fairness: both channels hold a read for 6 cycles ----------------
        // Last table grant was ch1, so the pointer is back at ch0.
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            clear_reqs();
            if (c < 6) begin
                set_cmd(0, 1'b0, 7'd5, 32'h0, 4'h0);
                set_cmd(1, 1'b0, 7'd3, 32'h0, 4'h0);
            end
            #1;
            if (c < 6) begin
                g = (c % 2 == 0) ? 2'b01 : 2'b10;
                check($sformatf("rr.gnt%0d", c), 64'(bus.ch_gnt), 64'(g));
                exp_q.push_back({g, (c % 2 == 0) ? 32'hA5A5_1234 : 32'hFF00_FF00});
            end
            if (c >= 2) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("rr.valid%0d", c), 64'(bus.rd_valid), 64'(e[NUM_CH+DW-1:DW]));
                    check($sformatf("rr.data%0d", c),  64'(bus.rd_data),  64'(e[DW-1:0]));
                end else begin
                    check("rr.queue_empty", 64'(1), 64'(0));
                end
            end
        end
        @(negedge clk);
        clear_reqs();
        check("rr.drained", 64'(bus.rd_valid), 64'(0));

        // ---------------- reset with reads in flight ----------------
        @(negedge clk);
        set_cmd(0, 1'b0, 7'd5, 32'h0, 4'h0);
        #1;
        check("rstf.gnt_a", 64'(bus.ch_gnt), 64'(2'b01));
        @(negedge clk);
        #1;
        check("rstf.gnt_b", 64'(bus.ch_gnt), 64'(2'b01));
        check("rstf.no_early", 64'(bus.rd_valid), 64'(0));
        #1;
        rst_n = 1'b0;
        clear_reqs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rstf.valid%0d", c), 64'(bus.rd_valid), 64'(0));
            check($sformatf("rstf.data%0d", c),  64'(bus.rd_data),  64'(0));
            check($sformatf("rstf.err%0d", c),   64'({bus.addr_err, bus.par_err}), 64'(0));
        end
        rst_n = 1'b1;
        last_rd = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rstf.post%0d", c), 64'(bus.rd_valid), 64'(0));
        end
        // Pointer was at ch1 before reset; after reset ch0 must win.
        set_cmd(0, 1'b0, 7'd5, 32'h0, 4'h0);
        set_cmd(1, 1'b0, 7'd3, 32'h0, 4'h0);
        #1;
        check("rstf.ptr0", 64'(bus.ch_gnt), 64'(2'b01));
        @(negedge clk);
        clear_reqs();
        @(negedge clk);
        check("rstf.ret_valid", 64'(bus.rd_valid), 64'(2'b01));
        check("rstf.ret_data",  64'(bus.rd_data),  64'(32'hA5A5_1234));
        last_rd = 32'hA5A5_1234;

        // ---------------- parity ----------------
        do_access("par.wr", 0, 1'b1, 7'd7, 32'h0F0F_0F0F, 4'hF, 32'h0, 1'b0, 1'b0);
        do_access("par.clean", 1, 1'b0, 7'd7, 32'h0, 4'h0, 32'h0F0F_0F0F, 1'b0, 1'b0);
`ifdef CDNSUSBHS_SPRAM_MC_PARITY_EN
        @(negedge clk);
        dut.u_core.r_mem[7][8] = ~dut.u_core.r_mem[7][8];
        do_access("par.flip", 0, 1'b0, 7'd7, 32'h0, 4'h0, 32'h0F0F_0F0F, 1'b0, 1'b1);
`else
        do_access("par.off", 0, 1'b0, 7'd7, 32'h0, 4'h0, 32'h0F0F_0F0F, 1'b0, 1'b0);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
